arb_mux_reg: RTL

- Parametrised N-bit, CH-channel operand selector for the multiplier-accumulator datapath.
- Successor to the fixed 2/3/4-to-1 combinational muxes.
- Selects one requesting channel by round-robin arbitration or by forced select, and registers the result into a single output stage.
- Uses valid/ready handshakes on every input channel and on the output, so the MAC can stall upstream producers.

---
 rtl/arb_mux_reg.sv | 94 +++++++++
 1 files changed

// File: rtl/arb_mux_reg.sv
// Operand selector for the MAC datapath. It picks one of CH valid/ready channels,
// either by round-robin or by forced select, and holds the result in one output register.
module arb_mux_reg #(
   parameter int N  = 8,
   parameter int CH = 4,
   parameter int SW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SW-1:0]     sel_ch,
   input  logic [CH-1:0]     in_valid,
   input  logic [CH*N-1:0]   in_data,
   output logic [CH-1:0]     in_ready,
   output logic              out_valid,
   output logic [N-1:0]      out_data,
   output logic [SW-1:0]     out_ch,
   input  logic              out_ready
);

   logic [SW-1:0] ptr;
   logic          vld_p0;
   logic [N-1:0]  data_p0;
   logic [SW-1:0] ch_p0;

   logic          load_en;
   logic          gnt_vld;
   logic [SW-1:0] gnt_idx;
   logic [N-1:0]  gnt_data;
   logic          xfer;

   assign load_en = !vld_p0 || out_ready;

   // Grant: forced channel in mode 1, otherwise the first requester found scanning from ptr.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (mode) begin
         for (int i = 0; i < CH; i++) begin
            if (sel_ch == SW'(i) && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SW'(i);
            end
         end
      end else begin
         for (int k = 0; k < CH; k++) begin
            automatic int idx = int'(ptr) + k;
            if (idx >= CH) idx = idx - CH;
            if (!gnt_vld && in_valid[idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = SW'(idx);
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < CH; i++) begin
         if (gnt_idx == SW'(i)) gnt_data = in_data[i*N +: N];
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < CH; i++) begin
         in_ready[i] = !rst && load_en && gnt_vld && (gnt_idx == SW'(i));
      end
   end

   assign xfer = |in_ready;

   // Output stage p0: refills in the same cycle it drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         ch_p0   <= '0;
         ptr     <= '0;
      end else if (xfer) begin
         vld_p0  <= 1'b1;
         data_p0 <= gnt_data;
         ch_p0   <= gnt_idx;
         if (!mode) ptr <= (gnt_idx == SW'(CH-1)) ? '0 : gnt_idx + SW'(1);
      end else if (out_ready) begin
         vld_p0  <= 1'b0;
      end
   end

   assign out_valid = vld_p0;
   assign out_data  = data_p0;
   assign out_ch    = ch_p0;

endmodule
